// File: rtl/decode_reg_if.sv
// Fetch -> decode -> immediate-gen/regfile handshake bundle for decode_reg.
// master = testbench/fetch side, slave = decode_reg.
interface decode_reg_if #(
  parameter int D_W = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [D_W-1:0] in_pc;
  logic [D_W-1:0] in_inst;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [D_W-1:0] out_pc;
  logic [2:0]     out_imm_sel;
  logic [D_W-8:0] out_upper_inst;
  logic [4:0]     out_rd;
  logic [4:0]     out_rs1;
  logic [4:0]     out_rs2;
  logic [2:0]     out_funct3;
  logic           out_illegal;

  modport master (
    output in_valid, in_pc, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_imm_sel, out_upper_inst,
           out_rd, out_rs1, out_rs2, out_funct3, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_inst, flush, out_ready,
    output in_ready, out_valid, out_pc, out_imm_sel, out_upper_inst,
           out_rd, out_rs1, out_rs2, out_funct3, out_illegal
  );
endinterface

// File: rtl/decode_reg.sv
// IF/ID register with opcode decode and a 2-entry skid buffer (registered in_ready).
// Optional ILLEGAL_SQUASH_EN: illegal beats are stored as a NOP with the PC kept.
module decode_reg #(
  parameter int D_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  decode_reg_if.slave bus
);

  typedef struct packed {
    logic [D_W-1:0] pc;
    logic [2:0]     imm_sel;
    logic [D_W-8:0] upper;
    logic           illegal;
  } beat_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   out_valid_q;
  logic   in_ready_q;
  beat_t  main_q;
  beat_t  skid_q;
  beat_t  dec;
  logic   acc, rel;
  logic   ld_main_in, ld_main_skid, ld_skid;

  // Opcode decode of the incoming beat; the result is what gets buffered.
  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.upper   = bus.in_inst[D_W-1:7];
    dec.illegal = 1'b0;
    unique case (bus.in_inst[6:0])
      7'b0010011: dec.imm_sel = 3'b000;
      7'b0000011: dec.imm_sel = 3'b001;
      7'b1100111: dec.imm_sel = 3'b110;
      7'b0100011: dec.imm_sel = 3'b010;
      7'b0110111,
      7'b0010111: dec.imm_sel = 3'b101;
      7'b1100011: dec.imm_sel = 3'b100;
      7'b1101111: dec.imm_sel = 3'b111;
      7'b0110011: dec.imm_sel = 3'b011;
      default: begin
        dec.imm_sel = 3'b000;
        dec.illegal = 1'b1;
`ifdef ILLEGAL_SQUASH_EN
        dec.upper   = '0;
`endif
      end
    endcase
  end

  assign acc = bus.in_valid & in_ready_q;
  assign rel = out_valid_q & bus.out_ready;

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (acc) begin
          state_d    = S_ONE;
          ld_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (acc && rel) begin
          ld_main_in = 1'b1;
        end else if (acc) begin
          state_d = S_FULL;
          ld_skid = 1'b1;
        end else if (rel) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (rel) begin
          state_d      = S_ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Redirect wins over any handshake; data registers are left as they are.
    if (bus.flush) begin
      state_d      = S_EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != S_EMPTY);
      in_ready_q  <= (state_d != S_FULL);
      if (ld_main_in)        main_q <= dec;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= dec;
    end
  end

  // Register fields are fixed slices of inst[31:7].
  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_pc         = main_q.pc;
  assign bus.out_imm_sel    = main_q.imm_sel;
  assign bus.out_upper_inst = main_q.upper;
  assign bus.out_rd         = main_q.upper[4:0];
  assign bus.out_funct3     = main_q.upper[7:5];
  assign bus.out_rs1        = main_q.upper[12:8];
  assign bus.out_rs2        = main_q.upper[17:13];
  assign bus.out_illegal    = main_q.illegal;

endmodule

// File: tb/tb_decode_reg.sv
// Randomized + directed bench for decode_reg against a queue-based reference model.
module tb_decode_reg;
  localparam int D_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_reg_if #(.D_W(D_W)) bus ();
  decode_reg #(.D_W(D_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } mbeat_t;

  mbeat_t q[$];
  logic   zero_shown;

`ifdef ILLEGAL_SQUASH_EN
  localparam bit SQUASH = 1'b1;
`else
  localparam bit SQUASH = 1'b0;
`endif

  // {illegal, imm_sel} from the opcode table
  function automatic logic [3:0] ref_dec(input logic [31:0] inst);
    case (inst[6:0])
      7'h13: return 4'b0000;
      7'h03: return 4'b0001;
      7'h67: return 4'b0110;
      7'h23: return 4'b0010;
      7'h37: return 4'b0101;
      7'h17: return 4'b0101;
      7'h63: return 4'b0100;
      7'h6F: return 4'b0111;
      7'h33: return 4'b0011;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [3:0]  d;
    logic [31:0] inst;
    logic        sq;
    chk("m_in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    chk("m_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      inst = q[0].inst;
      d    = ref_dec(inst);
      sq   = SQUASH && d[3];
      chk("m_pc", bus.out_pc, q[0].pc);
      chk("m_imm_sel", 32'(bus.out_imm_sel), 32'(d[2:0]));
      chk("m_illegal", 32'(bus.out_illegal), 32'(d[3]));
      chk("m_upper", 32'(bus.out_upper_inst), sq ? 32'd0 : (inst >> 7));
      chk("m_rd", 32'(bus.out_rd), sq ? 32'd0 : 32'(inst[11:7]));
      chk("m_rs1", 32'(bus.out_rs1), sq ? 32'd0 : 32'(inst[19:15]));
      chk("m_rs2", 32'(bus.out_rs2), sq ? 32'd0 : 32'(inst[24:20]));
      chk("m_funct3", 32'(bus.out_funct3), sq ? 32'd0 : 32'(inst[14:12]));
    end else if (zero_shown) begin
      chk("m_rst_pc", bus.out_pc, 32'd0);
      chk("m_rst_upper", 32'(bus.out_upper_inst), 32'd0);
      chk("m_rst_sel", 32'(bus.out_imm_sel), 32'd0);
      chk("m_rst_ill", 32'(bus.out_illegal), 32'd0);
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs checked at negedge.
  task automatic step();
    bit a, r;
    mbeat_t b;
    @(posedge clk);
    if (reset) begin
      q.delete();
      zero_shown = 1'b1;
    end else if (bus.flush) begin
      q.delete();
    end else begin
      r = (q.size() > 0) && bus.out_ready;
      a = bus.in_valid && (q.size() < 2);
      if (r) void'(q.pop_front());
      if (a) begin
        b.pc   = bus.in_pc;
        b.inst = bus.in_inst;
        q.push_back(b);
        zero_shown = 1'b0;
      end
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_inst  = inst;
  endtask

  logic [6:0] ops [10];

  initial begin
    zero_shown    = 1'b1;
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_upper", 32'(bus.out_upper_inst), 32'd0);

    // sw x5,8(x2)
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h100, 32'h00512423);
    step();
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_sel", 32'(bus.out_imm_sel), 32'b010);
    chk("t1_upper", 32'(bus.out_upper_inst), 32'h000A248);
    chk("t1_rs1", 32'(bus.out_rs1), 32'd2);
    chk("t1_rs2", 32'(bus.out_rs2), 32'd5);
    chk("t1_f3", 32'(bus.out_funct3), 32'b010);

    // back-to-back lui / jal / beq
    drive(1'b1, 32'h104, 32'h123450B7);
    step();
    chk("t2_lui_sel", 32'(bus.out_imm_sel), 32'b101);
    chk("t2_lui_rd", 32'(bus.out_rd), 32'd1);
    chk("t2_rdy0", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 32'h108, 32'h0100006F);
    step();
    chk("t2_jal_sel", 32'(bus.out_imm_sel), 32'b111);
    chk("t2_rdy1", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 32'h10C, 32'h00208463);
    step();
    chk("t2_beq_sel", 32'(bus.out_imm_sel), 32'b100);
    chk("t2_beq_pc", bus.out_pc, 32'h10C);
    drive(1'b0, 32'd0, 32'd0);
    step();

    // backpressure fills the skid
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h200, 32'h00100093);
    step();
    chk("t3_rdy_a", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 32'h204, 32'h002081B3);
    step();
    chk("t3_rdy_b", 32'(bus.in_ready), 32'd0);
    chk("t3_pc_b", bus.out_pc, 32'h200);
    drive(1'b1, 32'h208, 32'h00000013);
    step();
    chk("t3_hold_pc", bus.out_pc, 32'h200);
    chk("t3_hold_rdy", 32'(bus.in_ready), 32'd0);
    drive(1'b0, 32'd0, 32'd0);
    bus.out_ready = 1'b1;
    step();
    chk("t3_rel_pc", bus.out_pc, 32'h204);
    chk("t3_rel_rdy", 32'(bus.in_ready), 32'd1);
    step();
    chk("t3_empty", 32'(bus.out_valid), 32'd0);

    // flush while FULL with a beat offered
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h240, 32'h00100093);
    step();
    drive(1'b1, 32'h244, 32'h00100093);
    step();
    bus.flush = 1'b1;
    drive(1'b1, 32'h300, 32'h00000013);
    step();
    chk("t4_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_rdy", 32'(bus.in_ready), 32'd1);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0);
    step();
    chk("t4_gone", 32'(bus.out_valid), 32'd0);

    // illegal opcode
    drive(1'b1, 32'h400, 32'hFFFFFFFF);
    step();
    chk("t5_ill", 32'(bus.out_illegal), 32'd1);
    chk("t5_sel", 32'(bus.out_imm_sel), 32'd0);
    chk("t5_pc", bus.out_pc, 32'h400);
`ifdef ILLEGAL_SQUASH_EN
    chk("t5_upper", 32'(bus.out_upper_inst), 32'd0);
    chk("t5_rd", 32'(bus.out_rd), 32'd0);
`else
    chk("t5_upper", 32'(bus.out_upper_inst), 32'h1FFFFFF);
    chk("t5_rd", 32'(bus.out_rd), 32'h1F);
`endif
    drive(1'b0, 32'd0, 32'd0);
    step();

    // reset mid-FULL
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h500, 32'h00512423);
    step();
    drive(1'b1, 32'h504, 32'h123450B7);
    step();
    reset = 1'b1;
    step();
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rdy", 32'(bus.in_ready), 32'd1);
    chk("t6_pc", bus.out_pc, 32'd0);
    chk("t6_upper", 32'(bus.out_upper_inst), 32'd0);
    chk("t6_rs1", 32'(bus.out_rs1), 32'd0);
    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    step();

    // random traffic
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6F, 7'h33, 7'h7F};
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] inst;
      inst = $urandom;
      if ($urandom_range(0, 7) != 0) inst[6:0] = ops[$urandom_range(0, 9)];
      drive(1'($urandom_range(0, 3) != 0), $urandom, inst);
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      bus.flush     = 1'($urandom_range(0, 39) == 0);
      reset         = 1'($urandom_range(0, 199) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
